// File: rtl/t09_input_pkg.sv
// Shared constants and helpers for the t09 input conditioner.
//   DIR_*        one-hot direction encodings, bit order {up,down,left,right}
//   BTN_*        bit positions of each button within btn_raw / btn_level / btn_press
//   reverse_dir  returns the opposite direction of a one-hot direction
//                (all zeros for a non-one-hot input)
package t09_input_pkg;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam int BTN_DIR_LSB = 0;
  localparam int BTN_MODE    = 4;
  localparam int BTN_OBS     = 5;
  localparam int BTN_KEY     = 6;

  function automatic logic [3:0] reverse_dir(input logic [3:0] dir);
    logic [3:0] rev;
    rev = 4'b0000;
    case (dir)
      DIR_UP:    rev = DIR_DOWN;
      DIR_DOWN:  rev = DIR_UP;
      DIR_LEFT:  rev = DIR_RIGHT;
      DIR_RIGHT: rev = DIR_LEFT;
      default:   rev = 4'b0000;
    endcase
    return rev;
  endfunction

endpackage

// File: rtl/t09_input_conditioner_debounce.sv
// Single-bit conditioner: 2-FF synchronizer, counter debouncer and
// rising-edge pulse generator.
//   clk_i    system clock
//   nrst_i   asynchronous active-low reset
//   en_i     low = synchronous clear of every flop
//   raw_i    raw (asynchronous) button input
//   level_o  debounced level
//   press_o  one-cycle pulse, the cycle after level_o rises
module t09_debounce_bit
  import t09_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic en_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        level_dly_q;
  logic        press_q, press_d;
  logic [15:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level, and is cleared at CNT_LAST, so it never wraps.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = 16'd0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    // level_dly_q lags level_q by one cycle, so this pulse is registered
    // one cycle after the debounced level rises.
    press_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= 16'd0;
    end else if (!en_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/t09_input_conditioner.sv
// Input conditioner for the breakout-board pushbuttons. Every button is
// synchronized, debounced and edge-detected; direction presses are
// arbitrated into a single pending request that is committed on the game
// step pulse, never allowing a 180-degree reversal.
//   clk          system clock
//   nrst         asynchronous active-low reset
//   en           low = synchronous clear to reset state (step ignored)
//   btn_raw      raw buttons: [3:0] {up,down,left,right}, [4] mode,
//                [5] obstacle, [6] key
//   step         one-cycle game-step pulse
//   btn_level    debounced levels
//   btn_press    one-cycle pulse per debounced 0->1 transition
//   dir_out      committed one-hot direction {up,down,left,right}
//   dir_pending  an uncommitted valid direction request is held
module t09_input_conditioner
  import t09_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int          NUM_BTN         = 7
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               step,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [3:0]         dir_out,
  output logic               dir_pending
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    t09_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk),
      .nrst_i (nrst),
      .en_i   (en),
      .raw_i  (btn_raw[i]),
      .level_o(btn_level[i]),
      .press_o(btn_press[i])
    );
  end

  logic [3:0] dir_q, dir_d;
  logic [3:0] pend_dir_q, pend_dir_d;
  logic       pending_q, pending_d;
  logic [3:0] cand;
  logic       cand_ok;
  logic       commit_ok;

  // Fixed priority when several direction pulses coincide.
  always_comb begin
    cand = 4'b0000;
    if (btn_press[BTN_DIR_LSB + 3])      cand = DIR_UP;
    else if (btn_press[BTN_DIR_LSB + 2]) cand = DIR_DOWN;
    else if (btn_press[BTN_DIR_LSB + 1]) cand = DIR_LEFT;
    else if (btn_press[BTN_DIR_LSB])     cand = DIR_RIGHT;
  end

  // A new press is screened against the direction committed right now; the
  // pending value is screened again at commit because dir_q may have moved
  // in between (press landing in the same cycle as a step).
  assign cand_ok   = (cand != 4'b0000) && (cand != dir_q) &&
                     (cand != reverse_dir(dir_q));
  assign commit_ok = (pend_dir_q != dir_q) &&
                     (pend_dir_q != reverse_dir(dir_q));

  always_comb begin
    dir_d      = dir_q;
    pend_dir_d = pend_dir_q;
    pending_d  = pending_q;
    if (step && pending_q) begin
      pending_d = 1'b0;
      if (commit_ok) dir_d = pend_dir_q;
    end
    // Applied after the commit so a same-cycle press becomes the next request.
    if (cand_ok) begin
      pend_dir_d = cand;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dir_q      <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      pending_q  <= 1'b0;
    end else if (!en) begin
      dir_q      <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      pending_q  <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      pend_dir_q <= pend_dir_d;
      pending_q  <= pending_d;
    end
  end

  assign dir_out     = dir_q;
  assign dir_pending = pending_q;

endmodule

// File: tb/tb_t09_input_conditioner.sv
// Directed bench for t09_input_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_t09_input_conditioner;

  logic       clk = 1'b0;
  logic       nrst;
  logic       en;
  logic [6:0] btn_raw;
  logic       step;
  logic [6:0] btn_level;
  logic [6:0] btn_press;
  logic [3:0] dir_out;
  logic       dir_pending;

  int total = 0;
  int bad   = 0;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  t09_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .NUM_BTN        (7)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .en         (en),
    .btn_raw    (btn_raw),
    .step       (step),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .dir_out    (dir_out),
    .dir_pending(dir_pending)
  );

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [6:0] mask, input int n);
    btn_raw = mask;
    cyc(n);
    btn_raw = 7'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
  endtask

  function automatic logic [31:0] b2w(input logic b);
    return {31'b0, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dir"},   {28'b0, dir_out},   32'h1);
    check({tag, "_pend"},  b2w(dir_pending),   32'h0);
    check({tag, "_level"}, {25'b0, btn_level}, 32'h0);
    check({tag, "_press"}, {25'b0, btn_press}, 32'h0);
  endtask

  initial begin
    nrst    = 1'b0;
    en      = 1'b1;
    btn_raw = 7'b0;
    step    = 1'b0;
    cyc(2);
    check_idle("rst");

    // 1. idle after reset release
    nrst = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cyc(1);
      check_idle("idle");
    end

    // 2. short glitch is filtered, long press qualifies after 2+4 edges
    btn_raw[4] = 1'b1;
    cyc(3);
    btn_raw[4] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      check("glitch_lvl", b2w(btn_level[4]), 32'h0);
      check("glitch_prs", b2w(btn_press[4]), 32'h0);
    end
    btn_raw[4] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      check("mode_lvl", b2w(btn_level[4]), (k >= 6) ? 32'h1 : 32'h0);
      check("mode_prs", b2w(btn_press[4]), (k == 7) ? 32'h1 : 32'h0);
    end
    btn_raw[4] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      check("rel_lvl", b2w(btn_level[4]), (k < 6) ? 32'h1 : 32'h0);
      check("rel_prs", b2w(btn_press[4]), 32'h0);
    end

    // 3. up press from right, committed on step
    check("t3_dir0", {28'b0, dir_out}, 32'h1);
    btn_raw = 7'b0001000;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      check("t3_pend", b2w(dir_pending), (k >= 8) ? 32'h1 : 32'h0);
    end
    btn_raw = 7'b0;
    cyc(8);
    check("t3_dir_pre",  {28'b0, dir_out}, 32'h1);
    check("t3_pend_pre", b2w(dir_pending), 32'h1);
    pulse_step();
    check("t3_dir_post",  {28'b0, dir_out}, 32'h8);
    check("t3_pend_post", b2w(dir_pending), 32'h0);
    cyc(3);
    check("t3_dir_hold", {28'b0, dir_out}, 32'h8);

    // asynchronous reset between clock edges
    #2 nrst = 1'b0;
    #1;
    check_idle("async");
    @(negedge clk);
    nrst = 1'b1;

    // 4. reversal discarded; later valid press survives a discarded one
    hold(7'b0000010, 10);
    cyc(8);
    check("t4_rev_pend", b2w(dir_pending), 32'h0);
    pulse_step();
    check("t4_rev_dir",  {28'b0, dir_out}, 32'h1);
    check("t4_rev_pend2", b2w(dir_pending), 32'h0);
    hold(7'b0000100, 10);
    cyc(8);
    check("t4_down_pend", b2w(dir_pending), 32'h1);
    hold(7'b0000010, 10);
    cyc(8);
    check("t4_left_pend", b2w(dir_pending), 32'h1);
    pulse_step();
    check("t4_dir", {28'b0, dir_out}, 32'h4);
    check("t4_pend", b2w(dir_pending), 32'h0);

    // 5. simultaneous up+left, then step coinciding with a down press
    nrst = 1'b0;
    cyc(1);
    nrst = 1'b1;
    cyc(1);
    hold(7'b0001010, 10);
    cyc(8);
    check("t5_pend", b2w(dir_pending), 32'h1);
    check("t5_dir0", {28'b0, dir_out}, 32'h1);
    btn_raw = 7'b0000100;
    cyc(7);
    check("t5_down_prs", b2w(btn_press[2]), 32'h1);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    check("t5_commit_dir",  {28'b0, dir_out}, 32'h8);
    check("t5_commit_pend", b2w(dir_pending), 32'h1);
    cyc(2);
    btn_raw = 7'b0;
    cyc(8);
    pulse_step();
    check("t5_disc_dir",  {28'b0, dir_out}, 32'h8);
    check("t5_disc_pend", b2w(dir_pending), 32'h0);

    // 6. en dropped mid-debounce with a request pending
    hold(7'b0000010, 10);
    cyc(8);
    check("t6_pend_pre", b2w(dir_pending), 32'h1);
    btn_raw[6] = 1'b1;
    cyc(3);
    en = 1'b0;
    cyc(1);
    en = 1'b1;
    check("t6_dir",  {28'b0, dir_out}, 32'h1);
    check("t6_pend", b2w(dir_pending), 32'h0);
    check("t6_lvl0", {25'b0, btn_level}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      check("t6_key_lvl", b2w(btn_level[6]), (k >= 6) ? 32'h1 : 32'h0);
      check("t6_key_prs", b2w(btn_press[6]), (k == 7) ? 32'h1 : 32'h0);
    end
    btn_raw = 7'b0;
    cyc(8);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
